johnson_decoder: RTL and testbench
==================================

// Module: johnson_decoder
// PURPOSE
//  Receive-side companion to the 5-bit Johnson counter: samples a Johnson-coded bus and decodes it
//  to a binary index (0..2*WIDTH-1). Checks each code is legal and that successive valid samples
//  advance by exactly +1 mod 2*WIDTH. Runs a HUNT/LOCKED tracker and a saturating error counter.
//  Sits downstream of the counter (or any Johnson-coded source) in the Register/ALU sandbox.
// PARAMETERS
//  WIDTH       5   Johnson code width; sequence length is 2*WIDTH
//  LOCK_COUNT  3   consecutive correct +1 steps required to enter LOCKED (>=1)
//  ERR_W       8   error counter width
//  IDX_W       derived = $clog2(2*WIDTH) (4 for WIDTH=5); localparam, not overridable
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      code_in is sampled on this edge
//  code_in    in   WIDTH  Johnson-coded input
//  index_out  out  IDX_W  decoded index of last valid sample
//  idx_valid  out  1      1-cycle pulse: index_out/legal updated this cycle
//  legal      out  1      last valid sample was a legal Johnson code
//  step_err   out  1      1-cycle pulse: illegal code or wrong step while LOCKED
//  locked     out  1      tracker is in LOCKED
//  err_count  out  ERR_W  saturating count of step_err pulses
// BEHAVIOUR
//  Code map (k = index): k<=WIDTH -> low k bits 1, rest 0; k>WIDTH -> low k-WIDTH bits 0, rest 1.
//   Same sequence as next = {cur[WIDTH-2:0], ~cur[WIDTH-1]}.
//   WIDTH=5: 00000,00001,00011,00111,01111,11111,11110,11100,11000,10000 = k 0..9.
//  Decode: legal iff code is one of the 2*WIDTH patterns; p = popcount.
//   code[0]=1 -> k=p; code==0 -> k=0; else k=2*WIDTH-p.
//   Illegal codes: index_out holds its previous value; legal=0.
//  Latency: all outputs registered; one cycle after the sampling edge. in_valid=0 -> no update, pulses low.
//  Tracker FSM (states HUNT, VERIFY, LOCKED), prev = index of last legal valid sample:
//   HUNT:   legal sample -> capture prev, run=0, go VERIFY; illegal -> stay.
//   VERIFY: legal and k==prev+1 mod 2*WIDTH -> run++; LOCKED when run reaches LOCK_COUNT.
//           Otherwise: illegal -> HUNT; legal wrong step -> recapture prev, run=0.
//           No step_err outside LOCKED.
//   LOCKED: correct step -> stay; illegal or wrong step (incl. repeated code) -> step_err=1,
//           err_count += 1 (saturates at all-ones), go HUNT.
//  Wrap: 10000 (k=9) -> 00000 (k=0) is a correct step.
//  locked asserts in the same cycle as the idx_valid of the LOCK_COUNT-th correct step.
//  locked deasserts in the same cycle as step_err.
//  Reset (any time, incl. mid-sequence): state=HUNT, run=0, prev=0, index_out=0, idx_valid=0,
//   legal=0, step_err=0, locked=0, err_count=0. Takes effect immediately (asynchronous).
// STRUCTURE
//  johnson_pkg: tracker state enum; functions johnson_next(code) and johnson_index(code).
//   Shared with the counter and its bench.
//  Sub-module johnson_decode_comb: purely combinational, code_in -> {legal, index}.
//  johnson_decoder holds the registers, FSM and error counter.
// TESTING (WIDTH=5, LOCK_COUNT=3)
//  1 Drive all 10 legal codes in order, in_valid=1 each cycle -> index_out 0..9, legal=1 every
//    cycle, locked rises on the 4th idx_valid.
//  2 After lock, drive 10000 then 00000 -> wrap accepted: index 9 then 0, no step_err, locked stays 1.
//  3 While locked, inject 01010 -> legal=0, index_out holds, step_err pulse, err_count=1,
//    locked=0; then 4 correct codes relock.
//  4 While locked, repeat 00111 twice -> second sample gives step_err, err_count increments, HUNT.
//  5 Gaps: deassert in_valid between correct codes -> no pulses during gaps; lock still reached
//    after 4 valid samples.
//  6 Assert reset mid-sequence between clock edges -> all outputs 0 immediately.
//    Force 300 step errors -> err_count saturates at 255.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers: tracker state encoding, default-width code stepping and decoding.
// Used by the decoder here and by the 5-bit counter and its bench.
package johnson_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} trackState_t;

  localparam int JOHNSON_W     = 5;
  localparam int JOHNSON_IDX_W = $clog2(2 * JOHNSON_W);

  typedef struct packed {
    logic                     legal;
    logic [JOHNSON_IDX_W-1:0] index;
  } decode_t;

  // Mask with the low n bits set; callers truncate to their own code width.
  function automatic logic [31:0] low_ones(input int n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic logic [JOHNSON_W-1:0] johnson_next(input logic [JOHNSON_W-1:0] cur);
    return {cur[JOHNSON_W-2:0], ~cur[JOHNSON_W-1]};
  endfunction

  function automatic decode_t johnson_index(input logic [JOHNSON_W-1:0] code);
    decode_t              res;
    int                   p;
    int                   k;
    logic [JOHNSON_W-1:0] pat;
    p = $countones(code);
    if (code[0])        k = p;
    else if (code == '0) k = 0;
    else                k = 2 * JOHNSON_W - p;
    if (k <= JOHNSON_W) pat = JOHNSON_W'(low_ones(k));
    else                pat = ~JOHNSON_W'(low_ones(k - JOHNSON_W));
    res.legal = (code == pat);
    res.index = JOHNSON_IDX_W'(k);
    return res;
  endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// Combinational Johnson decode: popcount gives the candidate index, and the code is legal only
// if it matches the pattern regenerated from that index.
module johnson_decode_comb
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 5,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_legal,
  output logic [IDX_W-1:0] o_index
);

  int               w_pop;
  int               w_k;
  logic [WIDTH-1:0] w_pattern;

  always_comb begin
    w_pop = $countones(i_code);
    if (i_code[0])         w_k = w_pop;
    else if (i_code == '0) w_k = 0;
    else                   w_k = 2 * WIDTH - w_pop;
    if (w_k <= WIDTH) w_pattern = WIDTH'(low_ones(w_k));
    else              w_pattern = ~WIDTH'(low_ones(w_k - WIDTH));
    o_legal = (i_code == w_pattern);
    o_index = IDX_W'(w_k);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: registered decode, HUNT/VERIFY/LOCKED step tracker and a saturating
// error counter for step errors seen while locked.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int WIDTH      = 5,
  parameter  int LOCK_COUNT = 3,
  parameter  int ERR_W      = 8,
  localparam int IDX_W      = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] code_in,
  output logic [IDX_W-1:0] index_out,
  output logic             idx_valid,
  output logic             legal,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int SEQ_LEN = 2 * WIDTH;
  localparam int RUN_W   = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  trackState_t      r_state, w_nextState;
  logic [RUN_W-1:0] r_run, w_nextRun;
  logic [IDX_W-1:0] r_prev, w_nextPrev;
  logic [IDX_W-1:0] r_index;
  logic             r_idxValid, r_legal, r_stepErr;
  logic [ERR_W-1:0] r_errCount;

  logic             w_codeLegal;
  logic [IDX_W-1:0] w_codeIndex;
  logic [IDX_W-1:0] w_expectIdx;
  logic             w_goodStep;
  logic             w_runDone;
  logic             w_stepErr;

  johnson_decode_comb #(.WIDTH(WIDTH)) u_decode (
    .i_code  (code_in),
    .o_legal (w_codeLegal),
    .o_index (w_codeIndex)
  );

  assign w_expectIdx = (r_prev == IDX_W'(SEQ_LEN - 1)) ? '0 : r_prev + IDX_W'(1);
  assign w_goodStep  = w_codeLegal && (w_codeIndex == w_expectIdx);
  assign w_runDone   = (r_run == RUN_W'(LOCK_COUNT - 1));

  always_comb begin
    w_nextState = r_state;
    w_nextRun   = r_run;
    w_nextPrev  = r_prev;
    w_stepErr   = 1'b0;
    if (in_valid) begin
      if (w_codeLegal) w_nextPrev = w_codeIndex;
      unique case (r_state)
        HUNT: begin
          if (w_codeLegal) begin
            w_nextRun   = '0;
            w_nextState = VERIFY;
          end
        end
        VERIFY: begin
          if (w_goodStep) begin
            if (w_runDone) begin
              w_nextRun   = '0;
              w_nextState = LOCKED;
            end else begin
              w_nextRun = r_run + RUN_W'(1);
            end
          end else if (!w_codeLegal) begin
            w_nextRun   = '0;
            w_nextState = HUNT;
          end else begin
            w_nextRun = '0;
          end
        end
        LOCKED: begin
          if (!w_goodStep) begin
            w_stepErr   = 1'b1;
            w_nextRun   = '0;
            w_nextState = HUNT;
          end
        end
        default: w_nextState = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= HUNT;
      r_run      <= '0;
      r_prev     <= '0;
      r_index    <= '0;
      r_idxValid <= 1'b0;
      r_legal    <= 1'b0;
      r_stepErr  <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_run      <= w_nextRun;
      r_prev     <= w_nextPrev;
      r_idxValid <= in_valid;
      r_stepErr  <= w_stepErr;
      if (in_valid) begin
        r_legal <= w_codeLegal;
        if (w_codeLegal) r_index <= w_codeIndex;
      end
      if (w_stepErr && (r_errCount != {ERR_W{1'b1}})) r_errCount <= r_errCount + ERR_W'(1);
    end
  end

  assign index_out = r_index;
  assign idx_valid = r_idxValid;
  assign legal     = r_legal;
  assign step_err  = r_stepErr;
  assign locked    = (r_state == LOCKED);
  assign err_count = r_errCount;

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: a table-driven reference model predicts each sample's
// response into a queue, and an independent monitor pops and compares on every clock.
module tb_johnson_decoder;

  localparam int WIDTH      = 5;
  localparam int LOCK_COUNT = 3;
  localparam int ERR_W      = 8;
  localparam int SEQ        = 2 * WIDTH;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] code_in;
  logic [3:0]       index_out;
  logic             idx_valid, legal, step_err, locked;
  logic [ERR_W-1:0] err_count;

  johnson_decoder #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .code_in   (code_in),
    .index_out (index_out),
    .idx_valid (idx_valid),
    .legal     (legal),
    .step_err  (step_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int index;
    int legal;
    int stepErr;
    int locked;
    int errCount;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   total = 0;
  int   bad   = 0;
  int   illegalCodes[$];

  int   mdlIndex, mdlPrev, mdlStreak, mdlErr, mdlLegal, mdlLocked;

  // Code for index k straight from the code map: low k ones, or ones with k-WIDTH low zeros.
  function automatic int codeOf(input int k);
    if (k <= WIDTH) return (1 << k) - 1;
    return ((1 << WIDTH) - 1) & ~((1 << (k - WIDTH)) - 1);
  endfunction

  function automatic int findIndex(input int code);
    for (int k = 0; k < SEQ; k++) if (codeOf(k) == code) return k;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mdlIndex  = 0;
    mdlPrev   = 0;
    mdlStreak = -1;
    mdlErr    = 0;
    mdlLegal  = 0;
    mdlLocked = 0;
    expQ.delete();
  endtask

  // Streak counts consecutive +1 steps from an anchor sample; -1 means no anchor yet.
  task automatic applyStimulus(input bit v, input int code);
    int   k;
    int   err;
    exp_t e;
    @(negedge clk);
    in_valid = v;
    code_in  = WIDTH'(code);
    if (v) begin
      k   = findIndex(code);
      err = 0;
      if (k < 0) begin
        mdlLegal = 0;
        if (mdlLocked != 0) err = 1;
        mdlStreak = -1;
      end else begin
        mdlLegal = 1;
        mdlIndex = k;
        if (mdlStreak >= 0 && k == (mdlPrev + 1) % SEQ) mdlStreak++;
        else if (mdlLocked != 0) begin
          err       = 1;
          mdlStreak = -1;
        end else mdlStreak = 0;
        mdlPrev = k;
      end
      if (err != 0 && mdlErr < ERR_MAX) mdlErr++;
      mdlLocked  = (mdlStreak >= LOCK_COUNT) ? 1 : 0;
      e.index    = mdlIndex;
      e.legal    = mdlLegal;
      e.stepErr  = err;
      e.locked   = mdlLocked;
      e.errCount = mdlErr;
      expQ.push_back(e);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_index"}, index_out, 0);
    checkOutput({tag, "_idx_valid"}, idx_valid, 0);
    checkOutput({tag, "_legal"}, legal, 0);
    checkOutput({tag, "_step_err"}, step_err, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_err_count"}, err_count, 0);
  endtask

  // Monitor: one cycle after each sampling edge the DUT must show the queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) continue;
      if (expQ.size() > 0) begin
        monExp = expQ.pop_front();
        checkOutput("idx_valid", idx_valid, 1);
        checkOutput("index_out", index_out, monExp.index);
        checkOutput("legal", legal, monExp.legal);
        checkOutput("step_err", step_err, monExp.stepErr);
        checkOutput("locked", locked, monExp.locked);
        checkOutput("err_count", err_count, monExp.errCount);
      end else begin
        checkOutput("idle_idx_valid", idx_valid, 0);
        checkOutput("idle_step_err", step_err, 0);
        checkOutput("idle_locked", locked, mdlLocked);
        checkOutput("idle_err_count", err_count, mdlErr);
      end
    end
  end

  initial begin
    int r;
    int k;
    for (int c = 0; c < (1 << WIDTH); c++) if (findIndex(c) < 0) illegalCodes.push_back(c);

    reset    = 1'b1;
    in_valid = 1'b0;
    code_in  = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < SEQ; i++) applyStimulus(1'b1, codeOf(i));
    applyStimulus(1'b1, codeOf(0));
    for (int i = 1; i < SEQ; i++) applyStimulus(1'b1, codeOf(i));
    applyStimulus(1'b1, codeOf(0));

    applyStimulus(1'b1, 5'b01010);
    for (int i = 3; i <= 6; i++) applyStimulus(1'b1, codeOf(i));
    for (int i = 7; i < 10; i++) applyStimulus(1'b1, codeOf(i));
    for (int i = 0; i <= 3; i++) applyStimulus(1'b1, codeOf(i));
    applyStimulus(1'b1, codeOf(3));

    for (int i = 4; i <= 7; i++) begin
      applyStimulus(1'b1, codeOf(i));
      repeat ($urandom_range(1, 3)) applyStimulus(1'b0, codeOf(i));
    end

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      applyStimulus(1'b1, codeOf((mdlPrev + 1) % SEQ));
      else if (r == 6) applyStimulus(1'b0, $urandom_range(0, 31));
      else if (r == 7) applyStimulus(1'b1, codeOf($urandom_range(0, SEQ - 1)));
      else if (r == 8) applyStimulus(1'b1, illegalCodes[$urandom_range(0, illegalCodes.size() - 1)]);
      else             applyStimulus(1'b1, codeOf(mdlPrev));
    end

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, SEQ - 1);
      for (int j = 0; j <= LOCK_COUNT; j++) applyStimulus(1'b1, codeOf((k + j) % SEQ));
      applyStimulus(1'b1, illegalCodes[$urandom_range(0, illegalCodes.size() - 1)]);
    end
    applyStimulus(1'b0, 0);
    @(posedge clk);
    #2;
    checkOutput("err_saturated", err_count, ERR_MAX);

    for (int i = 2; i <= 7; i++) applyStimulus(1'b1, codeOf(i));
    @(posedge clk);
    #3;
    reset    = 1'b1;
    in_valid = 1'b0;
    modelReset();
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 5; i < 10; i++) applyStimulus(1'b1, codeOf(i));
    applyStimulus(1'b0, 0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
